// File: rtl/adder_share_pkg.sv
// Shared definitions for the adder-sharing sequencer: FSM states, default
// sizes and the small helpers used by the controller.
package adder_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREQ  = 2;

    // Signed overflow of a two's-complement add, judged on the effective B operand.
    function automatic logic calc_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, wrapping around. The pointer register lives in the caller.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_idx,
    output logic            grant_any
);

    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!grant_any && req[idx]) begin
                grant_any      = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/adder_share_ctrl.sv
// Time-shares one external combinational adder among NREQ requesters with
// round-robin grants, registered operands and a per-requester carry for chaining.
module adder_share_ctrl
    import adder_share_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ,
    parameter int ID_W  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_sub,
    input  logic [NREQ-1:0]       req_chain,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    output logic                  add_cin,
    input  logic [WIDTH-1:0]      add_sum,
    input  logic                  add_cout,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic                  rsp_ovf
);

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   owner;
    logic [NREQ-1:0]   carry;
    logic [NREQ-1:0]   grant;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_any;
    logic              accept;
    logic              take;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;
    logic              sel_sub;
    logic              sel_chain;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // A new operation can be accepted when idle, or when the pending result is
    // being consumed this cycle, which keeps back-to-back ops at one per two clocks.
    assign accept = (state == IDLE) || ((state == RESP) && rsp_ready);
    assign take   = accept && grant_any;

    always_comb begin
        sel_a     = req_a[int'(grant_idx) * WIDTH +: WIDTH];
        sel_b     = req_b[int'(grant_idx) * WIDTH +: WIDTH];
        sel_sub   = req_sub[grant_idx];
        sel_chain = req_chain[grant_idx];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = take ? EXEC : IDLE;
            EXEC:    state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = grant_any ? EXEC : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = accept ? grant : '0;
        rsp_valid = (state == RESP);
    end

    // Operand latch on a transfer; a subtract becomes A + ~B + 1 unless the
    // carry-in comes from the requester's stored no-borrow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            add_a   <= '0;
            add_b   <= '0;
            add_cin <= 1'b0;
            owner   <= '0;
            rr_ptr  <= '0;
        end else if (take) begin
            add_a   <= sel_a;
            add_b   <= sel_sub ? ~sel_b : sel_b;
            add_cin <= sel_chain ? carry[grant_idx] : sel_sub;
            owner   <= grant_idx;
            rr_ptr  <= ID_W'(rr_next(int'(grant_idx), NREQ));
        end
    end

    // Result capture after the adder has had a full cycle to settle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_id   <= '0;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
            rsp_ovf  <= 1'b0;
            carry    <= '0;
        end else if (state == EXEC) begin
            rsp_id       <= owner;
            rsp_sum      <= add_sum;
            rsp_cout     <= add_cout;
            rsp_ovf      <= calc_ovf(add_a[WIDTH-1], add_b[WIDTH-1], add_sum[WIDTH-1]);
            carry[owner] <= add_cout;
        end
    end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed bench for adder_share_ctrl; the shared adder is modelled here as a
// plain A+B+cin so the controller sees realistic combinational results.
module tb_adder_share_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [1:0]  req_sub;
    logic [1:0]  req_chain;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_sum;
    logic        add_cout;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_sum;
    logic        rsp_cout;
    logic        rsp_ovf;
    logic [32:0] full_sum;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign full_sum = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
    assign add_sum  = full_sum[31:0];
    assign add_cout = full_sum[32];

    adder_share_ctrl #(
        .WIDTH (32),
        .NREQ  (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .req_chain (req_chain),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf)
    );

    task automatic applyStimulus(input int idx, input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input logic chain);
        req_a[idx*32 +: 32] = a;
        req_b[idx*32 +: 32] = b;
        req_sub[idx]        = sub;
        req_chain[idx]      = chain;
    endtask

    // Called just after a falling edge; returns at the falling edge inside EXEC.
    task automatic issue_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                            input logic sub, input logic chain, output bit ok);
        ok = 1'b0;
        applyStimulus(idx, a, b, sub, chain);
        req_valid[idx] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (req_ready[idx]) begin
                @(posedge clk);
                @(negedge clk);
                req_valid[idx] = 1'b0;
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        req_valid[idx] = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (rsp_valid) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic chain, output bit ok);
        bit ok1;
        bit ok2;
        issue_op(idx, a, b, sub, chain, ok1);
        ok2 = 1'b0;
        if (ok1) wait_rsp(ok2);
        ok = ok1 && ok2;
    endtask

    task automatic accept_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_req_ready: got %b want 00", req_ready); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        vectors++; if ({add_a, add_b, add_cin} !== 65'd0) begin miscompares++; $display("[TB] FAIL reset_add_ops: got %h %h %b want 0", add_a, add_b, add_cin); end
        vectors++; if ({rsp_id, rsp_sum, rsp_cout, rsp_ovf} !== 35'd0) begin miscompares++; $display("[TB] FAIL reset_rsp_fields: got %b %h %b %b want 0", rsp_id, rsp_sum, rsp_cout, rsp_ovf); end
    endtask

    task automatic test_single_add();
        bit ok;
        issue_op(0, 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL single_grant: got no grant want grant"); end
        vectors++; if (add_a !== 32'h5 || add_b !== 32'h3 || add_cin !== 1'b0) begin miscompares++; $display("[TB] FAIL single_operands: got %h %h %b want 5 3 0", add_a, add_b, add_cin); end
        vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("[TB] FAIL single_exec_ready: got %b want 00", req_ready); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_exec_valid: got %b want 0", rsp_valid); end
        @(negedge clk);
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL single_latency: got %b want 1", rsp_valid); end
        vectors++; if (rsp_sum !== 32'h8 || rsp_cout !== 1'b0 || rsp_ovf !== 1'b0 || rsp_id !== 1'b0) begin miscompares++; $display("[TB] FAIL single_result: got %h %b %b id %0d want 8 0 0 id 0", rsp_sum, rsp_cout, rsp_ovf, rsp_id); end
        accept_rsp();
    endtask

    task automatic test_sub_ovf();
        bit ok;
        run_op(1, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL sub1_handshake: got timeout want response"); end
        vectors++; if (add_b !== 32'hFFFF_FFFE || add_cin !== 1'b1) begin miscompares++; $display("[TB] FAIL sub1_operands: got %h %b want fffffffe 1", add_b, add_cin); end
        vectors++; if (rsp_sum !== 32'h7FFF_FFFF || rsp_cout !== 1'b1 || rsp_ovf !== 1'b1 || rsp_id !== 1'b1) begin miscompares++; $display("[TB] FAIL sub1_result: got %h %b %b id %0d want 7fffffff 1 1 id 1", rsp_sum, rsp_cout, rsp_ovf, rsp_id); end
        accept_rsp();
        run_op(1, 32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL sub2_handshake: got timeout want response"); end
        vectors++; if (rsp_sum !== 32'hFFFF_FFFE || rsp_cout !== 1'b0 || rsp_ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL sub2_result: got %h %b %b want fffffffe 0 0", rsp_sum, rsp_cout, rsp_ovf); end
        accept_rsp();
    endtask

    task automatic test_chain64();
        bit ok;
        run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, ok);
        vectors++; if (!ok || rsp_sum !== 32'h0 || rsp_cout !== 1'b1 || rsp_ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL chain_lo: got ok %b %h %b %b want 1 0 1 0", ok, rsp_sum, rsp_cout, rsp_ovf); end
        accept_rsp();
        run_op(1, 32'h0000_0002, 32'h0000_0002, 1'b0, 1'b0, ok);
        vectors++; if (!ok || rsp_sum !== 32'h4 || rsp_id !== 1'b1) begin miscompares++; $display("[TB] FAIL chain_other: got ok %b %h id %0d want 1 4 id 1", ok, rsp_sum, rsp_id); end
        accept_rsp();
        run_op(0, 32'h0, 32'h0, 1'b0, 1'b1, ok);
        vectors++; if (!ok || add_cin !== 1'b1 || rsp_sum !== 32'h1 || rsp_cout !== 1'b0) begin miscompares++; $display("[TB] FAIL chain_hi: got ok %b cin %b %h %b want 1 1 1 0", ok, add_cin, rsp_sum, rsp_cout); end
        accept_rsp();
        run_op(1, 32'h0, 32'h0, 1'b0, 1'b1, ok);
        vectors++; if (!ok || add_cin !== 1'b0 || rsp_sum !== 32'h0) begin miscompares++; $display("[TB] FAIL chain_isolation: got ok %b cin %b %h want 1 0 0", ok, add_cin, rsp_sum); end
        accept_rsp();
    endtask

    task automatic test_contention();
        logic [1:0] exp_g;
        logic       exp_id;
        exp_g = 2'b01;
        applyStimulus(0, 32'h1, 32'h1, 1'b0, 1'b0);
        applyStimulus(1, 32'd10, 32'd20, 1'b0, 1'b0);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (c % 2 == 0) begin
                vectors++; if (req_ready !== exp_g) begin miscompares++; $display("[TB] FAIL contention_grant c%0d: got %b want %b", c, req_ready, exp_g); end
                exp_g = ~exp_g;
            end else begin
                vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("[TB] FAIL contention_exec_ready c%0d: got %b want 00", c, req_ready); end
            end
            if (c >= 2 && c % 2 == 0) begin
                exp_id = ((c / 2 - 1) % 2) == 1;
                vectors++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_sum !== (exp_id ? 32'd30 : 32'd2)) begin miscompares++; $display("[TB] FAIL contention_rsp c%0d: got v %b id %0d %h want v 1 id %0d", c, rsp_valid, rsp_id, rsp_sum, exp_id); end
            end else begin
                vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL contention_gap c%0d: got %b want 0", c, rsp_valid); end
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        #1;
        vectors++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_sum !== 32'd30) begin miscompares++; $display("[TB] FAIL contention_last: got v %b id %0d %h want v 1 id 1 1e", rsp_valid, rsp_id, rsp_sum); end
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL contention_drain: got %b want 0", rsp_valid); end
    endtask

    task automatic test_backpressure();
        bit ok;
        run_op(0, 32'd7, 32'd8, 1'b0, 1'b0, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL bp_handshake: got timeout want response"); end
        applyStimulus(1, 32'd100, 32'd1, 1'b0, 1'b0);
        req_valid[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            vectors++; if (rsp_valid !== 1'b1 || rsp_sum !== 32'd15 || rsp_id !== 1'b0 || req_ready !== 2'b00) begin miscompares++; $display("[TB] FAIL bp_hold c%0d: got v %b %h id %0d rdy %b want v 1 f id 0 rdy 00", c, rsp_valid, rsp_sum, rsp_id, req_ready); end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        vectors++; if (req_ready !== 2'b10) begin miscompares++; $display("[TB] FAIL bp_release_grant: got %b want 10", req_ready); end
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 2'b00;
        vectors++; if (add_a !== 32'd100 || rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_next_latch: got %h v %b want 64 v 0", add_a, rsp_valid); end
        wait_rsp(ok);
        vectors++; if (!ok || rsp_sum !== 32'd101 || rsp_id !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_next_result: got ok %b %h id %0d want 1 65 id 1", ok, rsp_sum, rsp_id); end
        accept_rsp();
    endtask

    task automatic test_reset_mid_op();
        bit ok;
        run_op(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, ok);
        vectors++; if (!ok || rsp_cout !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_setup: got ok %b cout %b want 1 1", ok, rsp_cout); end
        accept_rsp();
        issue_op(1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL rst_issue: got no grant want grant"); end
        reset = 1'b1;
        #1;
        vectors++; if (add_a !== 32'h0 || add_cin !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_async_clear: got %h %b want 0 0", add_a, add_cin); end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_no_rsp c%0d: got %b want 0", c, rsp_valid); end
            @(negedge clk);
        end
        run_op(0, 32'h0, 32'h0, 1'b0, 1'b1, ok);
        vectors++; if (!ok || add_cin !== 1'b0 || rsp_sum !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_carry0: got ok %b cin %b %h want 1 0 0", ok, add_cin, rsp_sum); end
        accept_rsp();
        run_op(1, 32'h0, 32'h0, 1'b0, 1'b1, ok);
        vectors++; if (!ok || add_cin !== 1'b0 || rsp_sum !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_carry1: got ok %b cin %b %h want 1 0 0", ok, add_cin, rsp_sum); end
        accept_rsp();
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 2'b00;
        req_a     = '0;
        req_b     = '0;
        req_sub   = 2'b00;
        req_chain = 2'b00;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_reset();
        @(negedge clk);
        test_single_add();
        test_sub_ovf();
        test_chain64();
        test_contention();
        @(negedge clk);
        test_backpressure();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
